state_transfer_ctrl: RTL

- Host-side initiator for the per-PE local data memory (LDM) port of the PE array.
- LOAD: accepts a valid/ready stream of complex state amplitudes and writes them into the PE LDMs, block-partitioned by global state index.
- UNLOAD: reads the state vector back out of the LDMs and emits it on a back-pressured output stream.
- Produces the single-cycle "state transfer done" pulse consumed by the array.

---
 rtl/state_transfer_ctrl_pkg.sv | 29 ++
 rtl/state_skid_fifo.sv | 69 ++++++
 rtl/state_transfer_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/state_transfer_ctrl_pkg.sv
// Shared definitions for state_transfer_ctrl: FSM encoding, default widths and PE slice helper.
package state_transfer_ctrl_pkg;

  localparam int PE_NUM_WIDTH_DEF     = 2;
  localparam int PE_NUM_DEF           = 4;
  localparam int DATA_WIDTH_DEF       = 32;
  localparam int MAX_QBIT_WIDTH_DEF   = 6;
  localparam int STATE_ADDR_WIDTH_DEF = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_UNLOAD = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_UNLOAD = ST_UNLOAD,
    S_DRAIN  = ST_DRAIN,
    S_DONE   = ST_DONE
  } state_e;

  // PE0 lives in the MSBs of every packed per-PE bus.
  function automatic int slice_lsb(input int p, input int n, input int w);
    return (n - 1 - p) * w;
  endfunction

endpackage

// File: rtl/state_skid_fifo.sv
// Two-entry FIFO holding LDM read data ahead of the back-pressured output stream.
module state_skid_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] m0_q, m0_d, m1_q, m1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  assign pop     = pop_i && (cnt_q != 2'd0);
  assign ready_o = (cnt_q != 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = m0_q;
  assign count_o = cnt_q;

  always_comb begin
    m0_d  = m0_q;
    m1_d  = m1_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_i, pop})
        2'b10: begin
          if (cnt_q == 2'd0) m0_d = data_i;
          else               m1_d = data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          m0_d  = m1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            m0_d = data_i;
          end else begin
            m0_d = m1_q;
            m1_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_q  <= '0;
      m1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      m0_q  <= m0_d;
      m1_q  <= m1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/state_transfer_ctrl.sv
// Host-side LDM initiator: streams a 2^q amplitude state vector into / out of the PE LDMs.
// Optional STATE_XFER_CHECKSUM_EN adds an XOR checksum output of all transferred amplitudes.
module state_transfer_ctrl
  import state_transfer_ctrl_pkg::*;
#(
  parameter int PE_NUM_WIDTH     = PE_NUM_WIDTH_DEF,
  parameter int PE_NUM           = PE_NUM_DEF,
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int MAX_QBIT_WIDTH   = MAX_QBIT_WIDTH_DEF,
  parameter int STATE_ADDR_WIDTH = STATE_ADDR_WIDTH_DEF,
  parameter int STATE_DATA_WIDTH = DATA_WIDTH * 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_load_start,
  input  logic                               i_unload_start,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic                               i_s_valid,
  output logic                               o_s_ready,
  input  logic [STATE_DATA_WIDTH-1:0]        i_s_data,
  output logic                               o_m_valid,
  input  logic                               i_m_ready,
  output logic [STATE_DATA_WIDTH-1:0]        o_m_data,
  output logic [PE_NUM*STATE_ADDR_WIDTH-1:0] o_ldm_addr,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_ldm_data,
  output logic [PE_NUM-1:0]                  o_ldm_en,
  output logic [PE_NUM-1:0]                  o_ldm_we,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_ldm_data,
  output logic                               o_done_state_transfer,
  output logic                               o_busy
`ifdef STATE_XFER_CHECKSUM_EN
  ,
  output logic [STATE_DATA_WIDTH-1:0]        o_checksum
`endif
);

  localparam int GW = MAX_QBIT_WIDTH + 1;
  localparam int AW = STATE_ADDR_WIDTH;
  localparam int DW = STATE_DATA_WIDTH;

  state_e                    state_q, state_d;
  logic [MAX_QBIT_WIDTH-1:0] q_q, q_d;
  logic [GW-1:0]             g_q, g_d;
  logic                      infl_q, infl_d;
  logic [PE_NUM_WIDTH-1:0]   rd_pe_q, rd_pe_d;

  logic [GW-1:0]             last_g;
  logic [PE_NUM_WIDTH-1:0]   sel_pe;
  logic [AW-1:0]             sel_addr;
  logic                      ldm_wr, rd_issue, acc, pop, start;
  logic                      fifo_rdy, fifo_vld;
  logic [1:0]                fifo_cnt;
  logic [DW-1:0]             fifo_head;
  logic [DW-1:0]             rd_slice [PE_NUM];

  assign last_g = (GW'(1) << q_q) - GW'(1);

  // Block partition: high bits of g pick the PE once there are more amplitudes than PEs.
  always_comb begin
    sel_pe   = '0;
    sel_addr = '0;
    if (q_q > MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) begin
      sel_pe   = PE_NUM_WIDTH'(g_q >> (q_q - MAX_QBIT_WIDTH'(PE_NUM_WIDTH)));
      sel_addr = AW'(g_q & ((GW'(1) << (q_q - MAX_QBIT_WIDTH'(PE_NUM_WIDTH))) - GW'(1)));
    end else begin
      sel_pe   = PE_NUM_WIDTH'(g_q);
    end
  end

  assign o_busy                = (state_q != S_IDLE);
  assign o_done_state_transfer = (state_q == S_DONE);
  assign o_m_valid             = fifo_vld && ((state_q == S_UNLOAD) || (state_q == S_DRAIN));
  assign o_m_data              = fifo_head;
  assign pop                   = o_m_valid && i_m_ready;
  assign acc                   = ldm_wr || rd_issue;
  assign start                 = (state_q == S_IDLE) && (i_load_start || i_unload_start);

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    g_d       = g_q;
    rd_pe_d   = rd_pe_q;
    o_s_ready = 1'b0;
    ldm_wr    = 1'b0;
    rd_issue  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_load_start) begin
          state_d = S_LOAD;
          q_d     = i_qbit_num;
          g_d     = '0;
        end else if (i_unload_start) begin
          state_d = S_UNLOAD;
          q_d     = i_qbit_num;
          g_d     = '0;
        end
      end
      S_LOAD: begin
        o_s_ready = 1'b1;
        if (i_s_valid) begin
          ldm_wr = 1'b1;
          g_d    = g_q + GW'(1);
          if (g_q == last_g) state_d = S_DONE;
        end
      end
      S_UNLOAD: begin
        // Skid occupancy plus the read in flight must never exceed two entries.
        if (fifo_rdy && ((fifo_cnt == 2'd0) || !infl_q || pop)) begin
          rd_issue = 1'b1;
          rd_pe_d  = sel_pe;
          g_d      = g_q + GW'(1);
          if (g_q == last_g) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((fifo_cnt == 2'd0) && !infl_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    infl_d = rd_issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      g_q     <= '0;
      infl_q  <= 1'b0;
      rd_pe_q <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      g_q     <= g_d;
      infl_q  <= infl_d;
      rd_pe_q <= rd_pe_d;
    end
  end

  for (genvar p = 0; p < PE_NUM; p++) begin : g_pe
    localparam int AL = slice_lsb(p, PE_NUM, AW);
    localparam int DL = slice_lsb(p, PE_NUM, DW);
    logic hit;
    assign hit                       = acc && (sel_pe == PE_NUM_WIDTH'(p));
    assign o_ldm_en[PE_NUM-1-p]      = hit;
    assign o_ldm_we[PE_NUM-1-p]      = hit && ldm_wr;
    assign o_ldm_addr[AL +: AW]      = hit ? sel_addr : '0;
    assign o_ldm_data[DL +: DW]      = (hit && ldm_wr) ? i_s_data : '0;
    assign rd_slice[p]               = i_ldm_data[DL +: DW];
  end

  state_skid_fifo #(.W(DW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (state_q == S_IDLE),
    .push_i  (infl_q),
    .data_i  (rd_slice[rd_pe_q]),
    .ready_o (fifo_rdy),
    .pop_i   (pop),
    .valid_o (fifo_vld),
    .data_o  (fifo_head),
    .count_o (fifo_cnt)
  );

`ifdef STATE_XFER_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start) csum_d = '0;
    if (ldm_wr) csum_d = csum_d ^ i_s_data;
    if (pop)    csum_d = csum_d ^ o_m_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign o_checksum = csum_q;
`endif

endmodule
